model_offset_ctrl: RTL and testbench

MODEL_OFFSET_CTRL -- requirements
Module: model_offset_ctrl

---
 rtl/model_offset_ctrl.sv | 162 ++++++++++++++++
 tb/tb_model_offset_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/model_offset_ctrl.sv
// Per-model X/Y/Z offset controller: tick-paced jog moves plus a three-state snapshot FSM.
// Optional saturation of X/Z at +/-LIMIT is enabled by defining MODEL_OFFSET_CLAMP_EN.
`timescale 1ns/1ps
module model_offset_ctrl #(
  parameter  int NUM_MODELS = 2,
  parameter  int FIXED_W    = 32,
  parameter  int FRAC_BITS  = 16,
  parameter  int TICK_BITS  = 21,
  parameter  int Y_INIT     = 11,
  parameter  int LIMIT      = 64,
  localparam int SEL_W      = (NUM_MODELS > 1) ? $clog2(NUM_MODELS) : 1,
  localparam int OUT_W      = 3 * FIXED_W * NUM_MODELS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic [SEL_W-1:0] sel,
  input  logic             strobe,
  output logic [OUT_W-1:0] offset,
  output logic [OUT_W-1:0] snap_offset,
  output logic             busy,
  output logic             valid
);

  localparam logic [FIXED_W-1:0] ONE_FX = FIXED_W'(1) << FRAC_BITS;
  localparam logic [FIXED_W-1:0] Y_FX   = FIXED_W'(Y_INIT) << FRAC_BITS;
  localparam logic signed [FIXED_W:0] LIM_P = (FIXED_W+1)'(LIMIT) << FRAC_BITS;
  localparam logic signed [FIXED_W:0] LIM_N = -LIM_P;
`ifdef MODEL_OFFSET_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // One jog step on one axis; inc wins over dec. The sum is kept one bit wider so the
  // saturating build can see an overflow before truncation.
  function automatic logic [FIXED_W-1:0] step_axis(input logic [FIXED_W-1:0] v,
                                                   input logic inc, input logic dec);
    logic [FIXED_W-1:0]      delta;
    logic signed [FIXED_W:0] sum;
    logic [FIXED_W-1:0]      res;
    if (inc)      delta = ONE_FX;
    else if (dec) delta = -ONE_FX;
    else          delta = '0;
    sum = $signed({v[FIXED_W-1], v}) + $signed({delta[FIXED_W-1], delta});
    if (CLAMP_EN && (sum > LIM_P))      res = LIM_P[FIXED_W-1:0];
    else if (CLAMP_EN && (sum < LIM_N)) res = LIM_N[FIXED_W-1:0];
    else                                res = sum[FIXED_W-1:0];
    return res;
  endfunction

  logic [TICK_BITS-1:0] cnt_q, cnt_d;
  logic                 tick_s;
  logic [FIXED_W-1:0]   x_q [NUM_MODELS];
  logic [FIXED_W-1:0]   x_d [NUM_MODELS];
  logic [FIXED_W-1:0]   z_q [NUM_MODELS];
  logic [FIXED_W-1:0]   z_d [NUM_MODELS];
  logic [FIXED_W-1:0]   snap_x_q [NUM_MODELS];
  logic [FIXED_W-1:0]   snap_x_d [NUM_MODELS];
  logic [FIXED_W-1:0]   snap_z_q [NUM_MODELS];
  logic [FIXED_W-1:0]   snap_z_d [NUM_MODELS];
  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;

  // Free-running tick divider and per-model jog update.
  always_comb begin
    cnt_d  = cnt_q + TICK_BITS'(1);
    tick_s = &cnt_q;
    for (int m = 0; m < NUM_MODELS; m++) begin
      x_d[m] = x_q[m];
      z_d[m] = z_q[m];
      if (tick_s && (int'(sel) < NUM_MODELS) && (int'(sel) == m)) begin
        x_d[m] = step_axis(x_q[m], left, right);
        z_d[m] = step_axis(z_q[m], up, down);
      end else begin
        x_d[m] = x_q[m];
        z_d[m] = z_q[m];
      end
    end
  end

  // Snapshot FSM; CAPTURE samples the registered offsets, so a concurrent tick is excluded.
  always_comb begin
    state_d = state_q;
    for (int m = 0; m < NUM_MODELS; m++) begin
      snap_x_d[m] = snap_x_q[m];
      snap_z_d[m] = snap_z_q[m];
    end
    case (state_q)
      IDLE: begin
        if (strobe) state_d = CAPTURE;
        else        state_d = IDLE;
      end
      CAPTURE: begin
        state_d = DONE;
        for (int m = 0; m < NUM_MODELS; m++) begin
          snap_x_d[m] = x_q[m];
          snap_z_d[m] = z_q[m];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int m = 0; m < NUM_MODELS; m++) begin
        x_q[m]      <= '0;
        z_q[m]      <= '0;
        snap_x_q[m] <= '0;
        snap_z_q[m] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      for (int m = 0; m < NUM_MODELS; m++) begin
        x_q[m]      <= x_d[m];
        z_q[m]      <= z_d[m];
        snap_x_q[m] <= snap_x_d[m];
        snap_z_q[m] <= snap_z_d[m];
      end
    end
  end

  // Pack X,Y,Z per model; Y never moves so it is a constant field.
  always_comb begin
    offset      = '0;
    snap_offset = '0;
    for (int m = 0; m < NUM_MODELS; m++) begin
      offset[m*3*FIXED_W +: FIXED_W]                 = x_q[m];
      offset[m*3*FIXED_W + FIXED_W +: FIXED_W]       = Y_FX;
      offset[m*3*FIXED_W + 2*FIXED_W +: FIXED_W]     = z_q[m];
      snap_offset[m*3*FIXED_W +: FIXED_W]             = snap_x_q[m];
      snap_offset[m*3*FIXED_W + FIXED_W +: FIXED_W]   = Y_FX;
      snap_offset[m*3*FIXED_W + 2*FIXED_W +: FIXED_W] = snap_z_q[m];
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_model_offset_ctrl.sv
// Directed bench for model_offset_ctrl with a 16-cycle tick; expectations follow
// the MODEL_OFFSET_CLAMP_EN setting of the build.
`timescale 1ns/1ps
module tb_model_offset_ctrl;
  localparam int NM = 2;
  localparam int FW = 32;
  localparam int W  = 3 * FW * NM;
  localparam int PERIOD = 16;
`ifdef MODEL_OFFSET_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  localparam logic [31:0] Y_EXP = 32'h000B_0000;

  logic         clk = 1'b0;
  logic         reset, up, down, left, right, strobe;
  logic [0:0]   sel;
  logic [W-1:0] offset, snap_offset;
  logic         busy, valid;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [3:0]   ph;

  typedef struct {
    logic        up, down, left, right;
    logic        sel;
    int          ticks;
    logic [31:0] x0, z0, x1, z1;
  } vec_t;
  vec_t tbl [7];

  model_offset_ctrl #(.NUM_MODELS(NM), .FIXED_W(FW), .FRAC_BITS(16), .TICK_BITS(4),
                      .Y_INIT(11), .LIMIT(2)) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .sel(sel), .strobe(strobe), .offset(offset), .snap_offset(snap_offset),
    .busy(busy), .valid(valid));

  always #5 clk = ~clk;

  // Reference phase of the tick divider: value the DUT counter holds this cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) ph <= 4'd0;
    else       ph <= ph + 4'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag, input int m, input logic [W-1:0] vec,
                           input logic [31:0] ex, input logic [31:0] ez);
    chk({tag, $sformatf("[%0d].x", m)}, vec[m*96 +: 32], ex);
    chk({tag, $sformatf("[%0d].y", m)}, vec[m*96 + 32 +: 32], Y_EXP);
    chk({tag, $sformatf("[%0d].z", m)}, vec[m*96 + 64 +: 32], ez);
  endtask

  task automatic set_moves(input logic u, input logic d, input logic l, input logic r,
                           input logic s);
    up = u; down = d; left = l; right = r; sel = s;
  endtask

  initial begin
    logic        seen_valid;
    logic [31:0] ex0, ez0, ex1, ez1;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3, 32'h0, 32'h0,
               CLAMP ? 32'h0002_0000 : 32'h0003_0000, CLAMP ? 32'h0002_0000 : 32'h0003_0000};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 32'h0, 32'h0001_0000,
               tbl[0].x1, tbl[0].z1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, CLAMP ? 32'hFFFE_0000 : 32'hFFFD_0000,
               32'h0001_0000, tbl[0].x1, tbl[0].z1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, CLAMP ? 32'hFFFF_0000 : 32'hFFFE_0000,
               32'h0001_0000, tbl[0].x1, tbl[0].z1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, tbl[3].x0, 32'hFFFF_0000,
               tbl[0].x1, tbl[0].z1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, tbl[3].x0, 32'hFFFF_0000,
               CLAMP ? 32'h0001_0000 : 32'h0002_0000, CLAMP ? 32'h0001_0000 : 32'h0002_0000};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, tbl[3].x0, 32'hFFFF_0000,
               tbl[5].x1, tbl[5].z1};

    reset = 1'b1; strobe = 1'b0;
    set_moves(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.valid", {31'b0, valid}, 32'd0);
    reset = 1'b0;

    // Idle after reset: nothing moves, no valid pulse.
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen_valid |= valid;
    end
    chk("idle.valid_seen", {31'b0, seen_valid}, 32'd0);
    for (int m = 0; m < NM; m++) begin
      chk_model("idle.offset", m, offset, 32'h0, 32'h0);
      chk_model("idle.snap", m, snap_offset, 32'h0, 32'h0);
    end

    // Each vector is held for whole tick periods, so exactly 'ticks' updates land.
    for (int i = 0; i < 7; i++) begin
      set_moves(tbl[i].up, tbl[i].down, tbl[i].left, tbl[i].right, tbl[i].sel);
      repeat (tbl[i].ticks * PERIOD) @(negedge clk);
      chk_model($sformatf("vec%0d", i), 0, offset, tbl[i].x0, tbl[i].z0);
      chk_model($sformatf("vec%0d", i), 1, offset, tbl[i].x1, tbl[i].z1);
    end
    chk_model("vec.snap_untouched", 0, snap_offset, 32'h0, 32'h0);
    ex0 = tbl[6].x0; ez0 = tbl[6].z0; ex1 = tbl[6].x1; ez1 = tbl[6].z1;

    // Snapshot whose CAPTURE cycle is also the tick cycle; a second strobe while busy.
    set_moves(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && ph != 4'd14; i++) @(negedge clk);
    chk("snap.align", {28'b0, ph}, 32'd14);
    strobe = 1'b1;
    set_moves(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("snap.capture.busy", {31'b0, busy}, 32'd1);
    chk("snap.capture.valid", {31'b0, valid}, 32'd0);
    @(negedge clk);
    chk("snap.done.valid", {31'b0, valid}, 32'd1);
    chk("snap.done.busy", {31'b0, busy}, 32'd1);
    chk_model("snap.pre_tick", 0, snap_offset, ex0, ez0);
    chk_model("snap.pre_tick", 1, snap_offset, ex1, ez1);
    ez0 = ez0 + 32'h0001_0000;
    chk_model("snap.live", 0, offset, ex0, ez0);
    set_moves(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    strobe = 1'b0;
    chk("snap.after.busy", {31'b0, busy}, 32'd0);
    chk("snap.after.valid", {31'b0, valid}, 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen_valid |= valid | busy;
    end
    chk("snap.no_requeue", {31'b0, seen_valid}, 32'd0);

    // Snapshot holds while the live offset moves.
    set_moves(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (PERIOD) @(negedge clk);
    set_moves(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_model("hold.live", 1, offset, ex1 + 32'h0001_0000, ez1);
    chk_model("hold.snap", 1, snap_offset, ex1, ez1);

    // Reset in the middle of CAPTURE: immediate clear, no valid afterwards.
    strobe = 1'b1;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    chk("abort.busy_pre", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort.busy", {31'b0, busy}, 32'd0);
    chk("abort.valid", {31'b0, valid}, 32'd0);
    for (int m = 0; m < NM; m++) begin
      chk_model("abort.snap", m, snap_offset, 32'h0, 32'h0);
      chk_model("abort.offset", m, offset, 32'h0, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    set_moves(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // First tick lands on the 16th edge after release.
    seen_valid = 1'b0;
    repeat (PERIOD - 1) begin
      @(negedge clk);
      seen_valid |= valid;
    end
    chk("release.z_before_tick", offset[64 +: 32], 32'h0);
    @(negedge clk);
    seen_valid |= valid;
    chk("release.z_after_tick", offset[64 +: 32], 32'h0001_0000);
    chk("release.valid_seen", {31'b0, seen_valid}, 32'd0);
    set_moves(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
